// File: rtl/ddr_arb_pkg.sv
// rtl/ddr_arb_pkg.sv - shared FSM encoding, buffer index type and helpers for ddr_frame_arbiter
package ddr_arb_pkg;

  // Arbiter FSM encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_GO   = 3'd1;
  localparam logic [2:0] ST_WR_WAIT = 3'd2;
  localparam logic [2:0] ST_RD_GO   = 3'd3;
  localparam logic [2:0] ST_RD_WAIT = 3'd4;

  // Index of one of the three frame buffers
  typedef logic [1:0] buf_idx_t;

  // Channel that received the most recent grant
  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } gnt_t;

  // Default geometry; the arbiter derives its own count from its parameters
  localparam int DEF_BURST_LEN    = 64;
  localparam int DEF_FRAME_BEATS  = 64800;
  localparam int BURSTS_PER_FRAME = DEF_FRAME_BEATS / DEF_BURST_LEN;

  // The buffer index that is neither a nor b (indices are 0, 1, 2)
  function automatic buf_idx_t third_buf(input buf_idx_t a, input buf_idx_t b);
    return 2'd3 - a - b;
  endfunction

endpackage

// File: rtl/ddr_frame_arbiter_if.sv
// rtl/ddr_frame_arbiter_if.sv - burst request/command handshake between arbiter and capture/display paths
interface ddr_frame_arbiter_if #(
  parameter int ADDR_W = 29
);

  logic              wr_req;
  logic              wr_start;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_end;
  logic              rd_req;
  logic              rd_start;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_end;

  // Arbiter side: issues commands, observes requests and completions
  modport master (
    input  wr_req,
    input  wr_end,
    input  rd_req,
    input  rd_end,
    output wr_start,
    output wr_addr,
    output rd_start,
    output rd_addr
  );

  // Requester / memory side
  modport slave (
    output wr_req,
    output wr_end,
    output rd_req,
    output rd_end,
    input  wr_start,
    input  wr_addr,
    input  rd_start,
    input  rd_addr
  );

endinterface

// File: rtl/ddr_arb_bufsel.sv
// rtl/ddr_arb_bufsel.sv - triple-buffer index bookkeeping and frame drop detection
module ddr_arb_bufsel
  import ddr_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     wr_wrap,
  input  logic     rd_wrap,
  output buf_idx_t wr_buf,
  output buf_idx_t rd_buf,
  output logic     frame_drop
);

  buf_idx_t wr_buf_q, wr_buf_d;
  buf_idx_t rd_buf_q, rd_buf_d;
  buf_idx_t last_done_q, last_done_d;
  logic     fresh_q, fresh_d;
  logic     frame_drop_q, frame_drop_d;

  // Rotate buffers on frame wraps; a completed frame nobody read yet is dropped
  always_comb begin
    wr_buf_d     = wr_buf_q;
    rd_buf_d     = rd_buf_q;
    last_done_d  = last_done_q;
    fresh_d      = fresh_q;
    frame_drop_d = 1'b0;
    if (wr_wrap) begin
      last_done_d  = wr_buf_q;
      wr_buf_d     = third_buf(wr_buf_q, rd_buf_q);
      fresh_d      = 1'b1;
      frame_drop_d = fresh_q;
    end else if (rd_wrap && fresh_q) begin
      rd_buf_d = last_done_q;
      fresh_d  = 1'b0;
    end
  end

  // Buffer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_buf_q     <= 2'd0;
      rd_buf_q     <= 2'd1;
      last_done_q  <= 2'd1;
      fresh_q      <= 1'b0;
      frame_drop_q <= 1'b0;
    end else begin
      wr_buf_q     <= wr_buf_d;
      rd_buf_q     <= rd_buf_d;
      last_done_q  <= last_done_d;
      fresh_q      <= fresh_d;
      frame_drop_q <= frame_drop_d;
    end
  end

  assign wr_buf     = wr_buf_q;
  assign rd_buf     = rd_buf_q;
  assign frame_drop = frame_drop_q;

endmodule

// File: rtl/ddr_frame_arbiter.sv
// rtl/ddr_frame_arbiter.sv - DDR burst arbiter for triple-buffered frame store; optional watchdog via DDR_ARB_TIMEOUT_EN
module ddr_frame_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int          BURST_LEN   = 64,
  parameter int          FRAME_BEATS = 64800,
  parameter int          ADDR_STEP   = 8,
  parameter logic [31:0] FRAME_SPAN  = 32'h0080_0000,
  parameter int          ADDR_W      = 29,
  parameter int          TIMEOUT_CYC = 4096
) (
  input  logic                wrclk,
  input  logic                rst_n,
  ddr_frame_arbiter_if.master bus,
  output buf_idx_t            wr_buf,
  output buf_idx_t            rd_buf,
  output logic                frame_drop,
  output logic                busy,
  output logic                timeout_err
);

  localparam int                BPF         = FRAME_BEATS / BURST_LEN;
  localparam int                CNT_W       = (BPF > 1) ? $clog2(BPF) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(BPF - 1);
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * ADDR_STEP);
  localparam logic [ADDR_W-1:0] SPAN        = ADDR_W'(FRAME_SPAN);

  // Start address of burst c inside frame buffer b, truncated to the bus width
  function automatic logic [ADDR_W-1:0] burst_addr(input buf_idx_t b, input logic [CNT_W-1:0] c);
    return ADDR_W'(b) * SPAN + ADDR_W'(c) * BURST_BYTES;
  endfunction

  logic [2:0]        state_q, state_d;
  logic              rd_pend_q, rd_pend_d;
  logic              wr_pend_q, wr_pend_d;
  gnt_t              last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              wr_start_q, wr_start_d;
  logic              rd_start_q, rd_start_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              wr_done, rd_done;
  logic              wr_wrap, rd_wrap;

`ifdef DDR_ARB_TIMEOUT_EN
  localparam int               WD_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_err_q, timeout_err_d;
`endif

  // Request latching, arbitration, command issue and burst completion
  always_comb begin
    state_d    = state_q;
    rd_pend_d  = rd_pend_q | bus.rd_req;
    wr_pend_d  = bus.wr_req;
    last_gnt_d = last_gnt_q;
    wr_start_d = 1'b0;
    rd_start_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    wr_done    = 1'b0;
    rd_done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Read wins when alone or when the write channel had the last grant
        if (rd_pend_q && (!wr_pend_q || last_gnt_q == GNT_WR)) begin
          state_d    = ST_RD_GO;
          rd_start_d = 1'b1;
          rd_addr_d  = burst_addr(rd_buf, rd_cnt_q);
          rd_pend_d  = bus.rd_req;
          last_gnt_d = GNT_RD;
        end else if (wr_pend_q) begin
          state_d    = ST_WR_GO;
          wr_start_d = 1'b1;
          wr_addr_d  = burst_addr(wr_buf, wr_cnt_q);
          last_gnt_d = GNT_WR;
        end
      end
      ST_WR_GO, ST_WR_WAIT: begin
        if (bus.wr_end) begin
          wr_done = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WR_WAIT;
        end
      end
      ST_RD_GO, ST_RD_WAIT: begin
        if (bus.rd_end) begin
          rd_done = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RD_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef DDR_ARB_TIMEOUT_EN
    // A stalled burst is abandoned without advancing its counter so it is reissued
    wd_cnt_d      = '0;
    timeout_err_d = timeout_err_q;
    if ((state_q == ST_WR_WAIT || state_q == ST_RD_WAIT) && !wr_done && !rd_done) begin
      if (wd_cnt_q == WD_LAST) begin
        state_d       = ST_IDLE;
        timeout_err_d = 1'b1;
        if (state_q == ST_RD_WAIT) begin
          rd_pend_d = 1'b1;
        end
      end else begin
        wd_cnt_d = wd_cnt_q + 1'b1;
      end
    end
`endif
  end

  // Per-channel burst counters; a wrap marks the end of a frame
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    wr_wrap  = 1'b0;
    rd_wrap  = 1'b0;
    if (wr_done) begin
      if (wr_cnt_q == CNT_LAST) begin
        wr_cnt_d = '0;
        wr_wrap  = 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end
    if (rd_done) begin
      if (rd_cnt_q == CNT_LAST) begin
        rd_cnt_d = '0;
        rd_wrap  = 1'b1;
      end else begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end
  end

  // Arbiter state registers
  always_ff @(posedge wrclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rd_pend_q  <= 1'b0;
      wr_pend_q  <= 1'b0;
      last_gnt_q <= GNT_WR;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      wr_start_q <= 1'b0;
      rd_start_q <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      rd_pend_q  <= rd_pend_d;
      wr_pend_q  <= wr_pend_d;
      last_gnt_q <= last_gnt_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_start_q <= wr_start_d;
      rd_start_q <= rd_start_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

`ifdef DDR_ARB_TIMEOUT_EN
  // Watchdog counter and sticky error flag
  always_ff @(posedge wrclk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  ddr_arb_bufsel u_bufsel (
    .clk        (wrclk),
    .rst_n      (rst_n),
    .wr_wrap    (wr_wrap),
    .rd_wrap    (rd_wrap),
    .wr_buf     (wr_buf),
    .rd_buf     (rd_buf),
    .frame_drop (frame_drop)
  );

  assign bus.wr_start = wr_start_q;
  assign bus.rd_start = rd_start_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.rd_addr  = rd_addr_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ddr_frame_arbiter.sv
// tb/tb_ddr_frame_arbiter.sv - randomized scoreboard bench for ddr_frame_arbiter
module tb_ddr_frame_arbiter;
  import ddr_arb_pkg::*;

  localparam int BL   = 4;
  localparam int FB   = 16;
  localparam int STEP = 8;
  localparam int SPAN = 'h1000;
  localparam int BPF  = FB / BL;
  localparam int TO   = 16;

  logic     clk = 1'b0;
  logic     rst_n = 1'b0;
  buf_idx_t wr_buf, rd_buf;
  logic     frame_drop, busy, timeout_err;

  ddr_frame_arbiter_if #(.ADDR_W(29)) bus();

  ddr_frame_arbiter #(
    .BURST_LEN   (BL),
    .FRAME_BEATS (FB),
    .ADDR_STEP   (STEP),
    .FRAME_SPAN  (32'h1000),
    .ADDR_W      (29),
    .TIMEOUT_CYC (TO)
  ) dut (
    .wrclk       (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .wr_buf      (wr_buf),
    .rd_buf      (rd_buf),
    .frame_drop  (frame_drop),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_rd;
    int addr;
  } cmd_t;

  cmd_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  int m_wbuf, m_rbuf, m_last, m_wcnt, m_rcnt;
  bit m_fresh, m_last_rd, m_rpend, wr_lvl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_wbuf = 0; m_rbuf = 1; m_last = 1; m_fresh = 0;
    m_wcnt = 0; m_rcnt = 0; m_last_rd = 0; m_rpend = 0; wr_lvl = 0;
  endtask

  function automatic int frame_addr(input int b, input int c);
    return b * SPAN + c * BL * STEP;
  endfunction

  // Scoreboard monitor: every command the DUT issues must match the oldest expectation
  initial begin
    cmd_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.wr_start || bus.rd_start)) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_cmd: got wr=%0d rd=%0d, expected no command", bus.wr_start, bus.rd_start);
        end else begin
          e = exp_q.pop_front();
          check("cmd_dir", {bus.wr_start, bus.rd_start}, e.is_rd ? 32'd1 : 32'd2);
          check("cmd_addr", e.is_rd ? 32'(bus.rd_addr) : 32'(bus.wr_addr), e.addr);
        end
      end
    end
  end

  // Raise requests if none pending, predict the grant and wait for its command
  task automatic issue(input bit allow_wr, input bit allow_rd, input bit tie, output bit g);
    int n;
    bit a_w, a_r, raised;
    cmd_t e;
    raised = 0;
    if (!m_rpend && !wr_lvl) begin
      a_w = tie || (allow_wr && ($urandom_range(0, 1) == 1));
      a_r = tie || (allow_rd && ($urandom_range(0, 1) == 1));
      if (!a_w && !a_r) begin
        if (allow_rd) a_r = 1; else a_w = 1;
      end
      wr_lvl = a_w;
      bus.wr_req = a_w;
      bus.rd_req = a_r;
      m_rpend = a_r;
      raised = 1;
    end
    g = m_rpend && (!wr_lvl || !m_last_rd);
    m_last_rd = g;
    if (g) m_rpend = 0;
    e.is_rd = g;
    e.addr = g ? frame_addr(m_rbuf, m_rcnt) : frame_addr(m_wbuf, m_wcnt);
    exp_q.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      bus.rd_req = 0;
      n++;
    end while (!(g ? bus.rd_start : bus.wr_start) && n < 8);
    check("cmd_latency", n, raised ? 2 : 1);
  endtask

  // mode 0: random, 1: keep both channels requesting, 2: no new requests
  task automatic finish(input bit g, input bit allow_rd, input int mode);
    int waitc, nb;
    bit drop_exp;
    waitc = (mode == 0) ? $urandom_range(0, 3) : 1;
    repeat (waitc) begin
      if (allow_rd && mode != 2 && (mode == 1 || $urandom_range(0, 2) == 0)) begin
        bus.rd_req = 1;
        m_rpend = 1;
      end
      if ($urandom_range(0, 2) == 0) begin
        if (g) bus.wr_end = 1; else bus.rd_end = 1;
      end
      @(negedge clk);
      bus.rd_req = 0; bus.wr_end = 0; bus.rd_end = 0;
    end
    if (g) bus.rd_end = 1; else bus.wr_end = 1;
    wr_lvl = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : ($urandom_range(0, 1) == 1);
    bus.wr_req = wr_lvl;
    drop_exp = 0;
    nb = 0;
    if (g) begin
      if (m_rcnt == BPF - 1) begin
        m_rcnt = 0;
        if (m_fresh) begin
          m_rbuf = m_last;
          m_fresh = 0;
        end
      end else m_rcnt++;
    end else if (m_wcnt == BPF - 1) begin
      m_wcnt = 0;
      drop_exp = m_fresh;
      m_last = m_wbuf;
      for (int i = 0; i < 3; i++) if (i != m_wbuf && i != m_rbuf) nb = i;
      m_wbuf = nb;
      m_fresh = 1;
    end else m_wcnt++;
    @(negedge clk);
    bus.wr_end = 0; bus.rd_end = 0;
    check("wr_buf", wr_buf, m_wbuf);
    check("rd_buf", rd_buf, m_rbuf);
    check("frame_drop", frame_drop, drop_exp);
    check("busy_idle", busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_start"}, bus.wr_start, 0);
    check({tag, "_rd_start"}, bus.rd_start, 0);
    check({tag, "_wr_addr"}, bus.wr_addr, 0);
    check({tag, "_rd_addr"}, bus.rd_addr, 0);
    check({tag, "_wr_buf"}, wr_buf, 0);
    check({tag, "_rd_buf"}, rd_buf, 1);
    check({tag, "_frame_drop"}, frame_drop, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin
    bit g;
    int n;
    cmd_t e;
    bus.wr_req = 0; bus.rd_req = 0; bus.wr_end = 0; bus.rd_end = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1;
    // Both channels from reset: read takes the first tie, then they alternate
    issue(1, 1, 1, g);
    finish(g, 1, 1);
    repeat (3) begin
      issue(1, 1, 0, g);
      finish(g, 1, 1);
    end
    // Writes only: frames complete with no reader, so frames get dropped
    repeat (12) begin
      issue(1, 0, 0, g);
      finish(g, 0, 0);
    end
    // Mixed random traffic
    repeat (40) begin
      issue(1, 1, 0, g);
      finish(g, 1, 0);
    end
    // Let outstanding requests drain
    while (m_rpend || wr_lvl) begin
      issue(1, 0, 0, g);
      finish(g, 0, 2);
    end
    // Reset while a write burst is in flight
    issue(1, 0, 0, g);
    @(negedge clk);
    rst_n = 0;
    bus.wr_req = 0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1;
    model_reset();
    issue(0, 1, 0, g);
    finish(g, 1, 2);
`ifdef DDR_ARB_TIMEOUT_EN
    // Withheld read completion: the same read is reissued after the watchdog fires
    issue(0, 1, 0, g);
    e.is_rd = 1;
    e.addr = frame_addr(m_rbuf, m_rcnt);
    exp_q.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rd_start && n < TO + 10);
    check("wd_retry_latency", n, TO + 2);
    check("wd_timeout_err", timeout_err, 1);
    finish(1, 1, 2);
    check("wd_timeout_sticky", timeout_err, 1);
`else
    n = 0;
    check("timeout_err_off", timeout_err, 0);
`endif
    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no completion, expected end of test");
    $fatal(1, "bench did not complete");
  end

endmodule
